// File: rtl/sram_ctrl_pkg.sv
// Shared types, SRAM command encodings and the training pattern for the
// training-SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRAIN_WR,
    RD,
    DRAIN,
    DONE
  } state_t;

  // Command bit order is {boot_mode, wren, rden}
  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_WRITE = 3'b010;
  localparam logic [2:0] CMD_READ  = 3'b101;

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    return addr + 32'd1;
  endfunction

endpackage

// File: rtl/sram_rd_checker.sv
// Readback compare pipeline and pass/fail status for a training pass.
// A read issued in one cycle is compared against its pattern word in the next.
module sram_rd_checker
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR  = 16,
  parameter int CW    = 5
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clear,
  input  logic             i_finish,
  input  logic             i_cmpValid,
  input  logic [ADDR-1:0]  i_cmpAddr,
  input  logic [WIDTH-1:0] i_rdata,
  output logic             o_pass,
  output logic [CW-1:0]    o_errCount,
  output logic [ADDR-1:0]  o_firstErrAddr,
  output logic             o_firstErrValid
);

  logic            r_stgValid;
  logic [ADDR-1:0] r_stgAddr;
  logic            r_pass;
  logic [CW-1:0]   r_errCount;
  logic [ADDR-1:0] r_firstErrAddr;
  logic            r_firstErrValid;

  logic [WIDTH-1:0] w_expWord;
  logic             w_mismatch;
  logic [CW-1:0]    w_errNext;

  assign w_expWord  = WIDTH'(exp_word(32'(r_stgAddr)));
  assign w_mismatch = r_stgValid && (i_rdata != w_expWord);
  assign w_errNext  = r_errCount + CW'(w_mismatch);

  // Pass verdict uses w_errNext so the compare finishing in DRAIN is counted
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_stgValid      <= 1'b0;
      r_stgAddr       <= '0;
      r_pass          <= 1'b0;
      r_errCount      <= '0;
      r_firstErrAddr  <= '0;
      r_firstErrValid <= 1'b0;
    end else if (i_clear) begin
      r_stgValid      <= 1'b0;
      r_stgAddr       <= '0;
      r_pass          <= 1'b0;
      r_errCount      <= '0;
      r_firstErrAddr  <= '0;
      r_firstErrValid <= 1'b0;
    end else begin
      r_stgValid <= i_cmpValid;
      r_stgAddr  <= i_cmpAddr;
      r_errCount <= w_errNext;
      if (w_mismatch && !r_firstErrValid) begin
        r_firstErrAddr  <= r_stgAddr;
        r_firstErrValid <= 1'b1;
      end
      if (i_finish) begin
        r_pass <= (w_errNext == '0);
      end
    end
  end

  assign o_pass          = r_pass;
  assign o_errCount      = r_errCount;
  assign o_firstErrAddr  = r_firstErrAddr;
  assign o_firstErrValid = r_firstErrValid;

endmodule

// File: rtl/sram_train_ctrl.sv
// Training-pass sequencer and single-port host arbiter for the training SRAM:
// one pattern-fill write, a full readback with compare, then host access.
module sram_train_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  parameter  int ADDR  = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             host_req,
  input  logic             host_wr,
  input  logic [ADDR-1:0]  host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic             host_gnt,
  output logic [WIDTH-1:0] host_rdata,
  output logic             host_rvalid,
  output logic             sram_wren,
  output logic             sram_rden,
  output logic             sram_boot_mode,
  output logic             sram_train_mode,
  output logic [WIDTH-1:0] sram_data_in,
  output logic [ADDR-1:0]  sram_addr,
  input  logic [WIDTH-1:0] sram_data_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_count,
  output logic [ADDR-1:0]  first_err_addr,
  output logic             first_err_valid
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST_RD = AW'(DEPTH - 1);
  localparam logic [ADDR-1:0] DEPTH_A = ADDR'(DEPTH);

  state_t r_state;
  state_t w_nextState;

  logic [AW-1:0] r_rdAddr;
  logic          r_busy;
  logic          r_done;
  logic          r_hostRvalid;
  logic          r_hostInRange;

  logic             w_idleLike;
  logic             w_startAcc;
  logic             w_hostInRange;
  logic             w_gnt;
  logic [2:0]       w_cmd;
  logic             w_trainMode;
  logic [ADDR-1:0]  w_sramAddr;
  logic [WIDTH-1:0] w_sramDataIn;

  assign w_idleLike    = (r_state == IDLE) || (r_state == DONE);
  assign w_startAcc    = start && w_idleLike;
  assign w_hostInRange = host_addr < DEPTH_A;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_nextState = TRAIN_WR;
      TRAIN_WR:   w_nextState = RD;
      RD:         if (r_rdAddr == LAST_RD) w_nextState = DRAIN;
      DRAIN:      w_nextState = DONE;
      default:    w_nextState = IDLE;
    endcase
  end

  // Read pointer rests at zero so the first RD cycle always issues address 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdAddr <= '0;
    end else if (r_state == RD) begin
      r_rdAddr <= r_rdAddr + 1'b1;
    end else begin
      r_rdAddr <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_hostRvalid  <= 1'b0;
      r_hostInRange <= 1'b0;
    end else begin
      if (w_startAcc) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end else if (r_state == DRAIN) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      r_hostRvalid  <= w_gnt && !host_wr;
      r_hostInRange <= w_hostInRange;
    end
  end

  // Out-of-range host addresses are granted but never reach the SRAM
  always_comb begin
    w_cmd        = CMD_IDLE;
    w_trainMode  = 1'b0;
    w_sramAddr   = '0;
    w_sramDataIn = '0;
    w_gnt        = 1'b0;
    case (r_state)
      TRAIN_WR: begin
        w_cmd       = CMD_WRITE;
        w_trainMode = 1'b1;
      end
      RD: begin
        w_cmd      = CMD_READ;
        w_sramAddr = ADDR'(r_rdAddr);
      end
      IDLE, DONE: begin
        w_gnt = host_req && !start;
        if (w_gnt && w_hostInRange) begin
          w_sramAddr = host_addr;
          if (host_wr) begin
            w_cmd        = CMD_WRITE;
            w_sramDataIn = host_wdata;
          end else begin
            w_cmd = CMD_READ;
          end
        end
      end
      default: ;
    endcase
  end

  assign sram_boot_mode  = w_cmd[2];
  assign sram_wren       = w_cmd[1];
  assign sram_rden       = w_cmd[0];
  assign sram_train_mode = w_trainMode;
  assign sram_addr       = w_sramAddr;
  assign sram_data_in    = w_sramDataIn;

  assign host_gnt    = w_gnt;
  assign host_rvalid = r_hostRvalid;
  assign host_rdata  = (r_hostRvalid && r_hostInRange) ? sram_data_out : '0;

  assign busy = r_busy;
  assign done = r_done;

  sram_rd_checker #(
    .WIDTH (WIDTH),
    .ADDR  (ADDR),
    .CW    (CW)
  ) u_checker (
    .i_clk           (clk),
    .i_rstn          (rstn),
    .i_clear         (w_startAcc),
    .i_finish        (r_state == DRAIN),
    .i_cmpValid      (r_state == RD),
    .i_cmpAddr       (ADDR'(r_rdAddr)),
    .i_rdata         (sram_data_out),
    .o_pass          (pass),
    .o_errCount      (err_count),
    .o_firstErrAddr  (first_err_addr),
    .o_firstErrValid (first_err_valid)
  );

endmodule

// File: tb/tb_sram_train_ctrl.sv
// Self-checking bench for sram_train_ctrl with a behavioural training SRAM,
// fault injection on readback and a host-side memory scoreboard.
module tb_sram_train_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int ADDR  = 16;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic             host_req;
  logic             host_wr;
  logic [ADDR-1:0]  host_addr;
  logic [WIDTH-1:0] host_wdata;
  logic             host_gnt;
  logic [WIDTH-1:0] host_rdata;
  logic             host_rvalid;
  logic             sram_wren;
  logic             sram_rden;
  logic             sram_boot_mode;
  logic             sram_train_mode;
  logic [WIDTH-1:0] sram_data_in;
  logic [ADDR-1:0]  sram_addr;
  logic [WIDTH-1:0] sram_data_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CW-1:0]    err_count;
  logic [ADDR-1:0]  first_err_addr;
  logic             first_err_valid;

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_train_ctrl dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .host_req        (host_req),
    .host_wr         (host_wr),
    .host_addr       (host_addr),
    .host_wdata      (host_wdata),
    .host_gnt        (host_gnt),
    .host_rdata      (host_rdata),
    .host_rvalid     (host_rvalid),
    .sram_wren       (sram_wren),
    .sram_rden       (sram_rden),
    .sram_boot_mode  (sram_boot_mode),
    .sram_train_mode (sram_train_mode),
    .sram_data_in    (sram_data_in),
    .sram_addr       (sram_addr),
    .sram_data_out   (sram_data_out),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_addr  (first_err_addr),
    .first_err_valid (first_err_valid)
  );

  // Behavioural SRAM with optional per-address readback corruption
  logic [7:0] mem      [DEPTH];
  logic [7:0] refMem   [DEPTH];
  bit         faultEn  [DEPTH];
  logic [7:0] faultVal [DEPTH];
  logic [7:0] sramDataOut = 8'h00;

  assign sram_data_out = sramDataOut;

  always @(posedge clk) begin
    if (sram_wren) begin
      if (sram_train_mode) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i + 1);
      end else if (32'(sram_addr) < DEPTH) begin
        mem[sram_addr[3:0]] <= sram_data_in;
      end
    end
    if (sram_rden) begin
      if (32'(sram_addr) >= DEPTH) sramDataOut <= 8'h00;
      else if (faultEn[sram_addr[3:0]]) sramDataOut <= faultVal[sram_addr[3:0]];
      else sramDataOut <= mem[sram_addr[3:0]];
    end
  end

  // Bus monitor for the training sequence
  bit monOn = 1'b0;
  int trainWrCnt;
  int rdAddrQ[$];
  bit bothSeen;
  bit bootBad;

  always begin
    @(negedge clk);
    #2;
    if (sram_wren && sram_rden) bothSeen = 1'b1;
    if ((sram_rden && !sram_boot_mode) || (sram_wren && sram_boot_mode)) bootBad = 1'b1;
    if (monOn) begin
      if (sram_wren && sram_train_mode) trainWrCnt++;
      if (sram_rden && busy) rdAddrQ.push_back(int'(sram_addr));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One host access in IDLE/DONE; writes update the scoreboard memory
  task automatic applyStimulus(input string name, input bit wr, input logic [15:0] addr,
                               input logic [7:0] wdata, input logic [7:0] expRdata);
    bit inRange;
    inRange = (32'(addr) < DEPTH);
    @(negedge clk);
    host_req   = 1'b1;
    host_wr    = wr;
    host_addr  = addr;
    host_wdata = wdata;
    #1;
    checkOutput({name, "_gnt"}, host_gnt, 1);
    checkOutput({name, "_wren"}, sram_wren, wr && inRange);
    checkOutput({name, "_rden"}, sram_rden, !wr && inRange);
    if (inRange) checkOutput({name, "_addr"}, sram_addr, addr);
    if (wr && inRange) checkOutput({name, "_wdata"}, sram_data_in, wdata);
    @(posedge clk);
    #1;
    host_req = 1'b0;
    checkOutput({name, "_rvalid"}, host_rvalid, !wr);
    if (!wr) checkOutput({name, "_rdata"}, host_rdata, expRdata);
    if (wr && inRange) refMem[addr[3:0]] = wdata;
  endtask

  // Full training pass; expected verdict derived from the fault table
  task automatic runPass(input string tag, input bit withHost, input int pulseAt);
    int expErr;
    int expFirst;
    bit expFirstValid;
    int edges;
    bit seqOk;
    logic [7:0] got;
    expErr = 0;
    expFirst = 0;
    expFirstValid = 1'b0;
    edges = 0;
    for (int a = 0; a < DEPTH; a++) begin
      got = faultEn[a] ? faultVal[a] : 8'(a + 1);
      if (got != 8'(a + 1)) begin
        if (!expFirstValid) begin
          expFirst = a;
          expFirstValid = 1'b1;
        end
        expErr++;
      end
    end
    trainWrCnt = 0;
    rdAddrQ.delete();
    bothSeen = 1'b0;
    bootBad = 1'b0;
    monOn = 1'b1;
    @(negedge clk);
    start = 1'b1;
    if (withHost) begin
      host_req  = 1'b1;
      host_wr   = 1'b0;
      host_addr = 16'd4;
      #1;
      checkOutput({tag, "_gnt_vs_start"}, host_gnt, 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    host_req = 1'b0;
    checkOutput({tag, "_busy_start"}, busy, 1);
    checkOutput({tag, "_done_cleared"}, done, 0);
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
      start = 1'b0;
      if (edges == pulseAt) start = 1'b1;
      if (edges == 3) begin
        host_req  = 1'b1;
        host_wr   = 1'b0;
        host_addr = 16'd2;
        #1;
        checkOutput({tag, "_gnt_busy"}, host_gnt, 0);
        host_req = 1'b0;
      end
    end
    monOn = 1'b0;
    checkOutput({tag, "_done_edge"}, edges, DEPTH + 2);
    checkOutput({tag, "_busy_end"}, busy, 0);
    checkOutput({tag, "_pass"}, pass, expErr == 0);
    checkOutput({tag, "_err_count"}, err_count, expErr);
    checkOutput({tag, "_first_valid"}, first_err_valid, expFirstValid);
    checkOutput({tag, "_first_addr"}, first_err_addr, expFirstValid ? expFirst : 0);
    checkOutput({tag, "_train_wr"}, trainWrCnt, 1);
    seqOk = (rdAddrQ.size() == DEPTH);
    for (int i = 0; i < rdAddrQ.size(); i++) if (rdAddrQ[i] != i) seqOk = 1'b0;
    checkOutput({tag, "_rd_seq"}, seqOk, 1);
    checkOutput({tag, "_wr_rd_excl"}, bothSeen, 0);
    checkOutput({tag, "_boot_mode"}, bootBad, 0);
    for (int i = 0; i < DEPTH; i++) refMem[i] = 8'(i + 1);
  endtask

  typedef struct {
    bit         wr;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] expRdata;
  } hostVec_t;

  hostVec_t vecs[10];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 16'd3,  8'h00, 8'h04};
    vecs[1] = '{1'b1, 16'd3,  8'hA5, 8'h00};
    vecs[2] = '{1'b0, 16'd3,  8'h00, 8'hA5};
    vecs[3] = '{1'b0, 16'd20, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 16'd20, 8'h5A, 8'h00};
    vecs[5] = '{1'b0, 16'd20, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 16'd15, 8'h00, 8'h10};
    vecs[7] = '{1'b1, 16'd15, 8'h3C, 8'h00};
    vecs[8] = '{1'b0, 16'd15, 8'h00, 8'h3C};
    vecs[9] = '{1'b0, 16'd0,  8'h00, 8'h01};
    for (int i = 0; i < DEPTH; i++) begin
      faultEn[i]  = 1'b0;
      faultVal[i] = 8'h00;
      refMem[i]   = 8'h00;
    end

    rstn = 1'b0;
    start = 1'b0;
    host_req = 1'b0;
    host_wr = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_first_addr", first_err_addr, 0);
    checkOutput("rst_first_valid", first_err_valid, 0);
    checkOutput("rst_rvalid", host_rvalid, 0);
    checkOutput("rst_rdata", host_rdata, 0);
    checkOutput("rst_strobes", {sram_wren, sram_rden, sram_boot_mode, sram_train_mode}, 0);
    checkOutput("rst_gnt", host_gnt, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("idle_gnt", host_gnt, 0);
    checkOutput("idle_strobes", {sram_wren, sram_rden}, 0);

    runPass("pass1", 1'b1, 6);

    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].expRdata);
    end
    checkOutput("done_kept", done, 1);
    checkOutput("pass_kept", pass, 1);

    faultEn[5] = 1'b1;  faultVal[5] = 8'h00;
    faultEn[9] = 1'b1;  faultVal[9] = 8'hFF;
    runPass("fault59", 1'b0, 0);
    for (int i = 0; i < DEPTH; i++) faultEn[i] = 1'b0;

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        faultEn[i]  = ($urandom_range(0, 3) == 0);
        faultVal[i] = 8'($urandom);
      end
      runPass($sformatf("rnd%0d", p), 1'b0, 0);
    end
    for (int i = 0; i < DEPTH; i++) faultEn[i] = 1'b0;

    for (int n = 0; n < 120; n++) begin
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  expRd;
      wr    = 1'($urandom_range(0, 1));
      addr  = 16'($urandom_range(0, 23));
      wdata = 8'($urandom);
      expRd = (32'(addr) < DEPTH) ? refMem[addr[3:0]] : 8'h00;
      applyStimulus($sformatf("rhost%0d", n), wr, addr, wdata, expRd);
    end

    faultEn[2] = 1'b1;
    faultVal[2] = 8'h77;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("midrst_err_before", err_count, 1);
    checkOutput("midrst_rden_before", sram_rden, 1);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_err", err_count, 0);
    checkOutput("midrst_first_valid", first_err_valid, 0);
    checkOutput("midrst_strobes", {sram_wren, sram_rden, sram_boot_mode, sram_train_mode}, 0);
    faultEn[2] = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    runPass("post_rst", 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
